// File: rtl/icache_pkg.sv
// Shared types and widths for the direct-mapped instruction cache controller.
package icache_pkg;

    localparam int CPU_ADDR_W = 12;
    localparam int MEM_ADDR_W = 8;
    localparam int LINE_W     = 128;
    localparam int WORD_W     = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        REFILL  = 2'd2
    } state_t;

    // A 256-line cache has no tag bits left; keep a 1-bit tag tied to zero.
    function automatic int tag_width(input int idx_w);
        return (idx_w >= MEM_ADDR_W) ? 1 : MEM_ADDR_W - idx_w;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: one synchronous write port, one combinational read port.
module icache_array
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = tag_width(IDX_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_all,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_W-1:0]    data_mem [NUM_LINES];

    always_ff @(posedge clk) begin
        if (reset || clear_all) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset; the valid bit alone qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache: fetch FSM, line refill handshake and perf counters.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic [CPU_ADDR_W-1:0] cpu_addr,
    output logic                  cpu_ready,
    output logic [WORD_W-1:0]     cpu_instr,
    output logic                  cpu_valid,
    input  logic                  flush,
    output logic                  mem_req_out,
    output logic [MEM_ADDR_W-1:0] mem_addr_out,
    input  logic [LINE_W-1:0]     mem_data_in,
    input  logic                  mem_done_in,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = tag_width(IDX_W);

    state_t                  state_q, state_d;
    logic [CPU_ADDR_W-1:2]   addr_q, addr_d;
    logic                    valid_q, valid_d;
    logic [WORD_W-1:0]       instr_q, instr_d;
    logic                    mem_req_q, mem_req_d;
    logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                    req_seen_q, req_seen_d;
    logic                    refilled_q, refilled_d;
    logic [15:0]             hit_cnt_q, hit_cnt_d;
    logic [15:0]             miss_cnt_q, miss_cnt_d;

    logic [MEM_ADDR_W-1:0]   line_addr;
    logic [MEM_ADDR_W-1:0]   tag_full;
    logic [IDX_W-1:0]        idx;
    logic [TAG_W-1:0]        tag;
    logic [1:0]              word_sel;
    logic                    arr_valid;
    logic [TAG_W-1:0]        arr_tag;
    logic [LINE_W-1:0]       arr_data;
    logic [WORD_W-1:0]       sel_word;
    logic                    hit;
    logic                    clear_all;
    logic                    wr_en;
    logic                    addr_unused;

    assign addr_unused = ^cpu_addr[1:0];

    assign line_addr = addr_q[CPU_ADDR_W-1:4];
    assign tag_full  = line_addr >> IDX_W;
    assign idx       = line_addr[IDX_W-1:0];
    assign tag       = tag_full[TAG_W-1:0];
    assign word_sel  = addr_q[3:2];
    assign sel_word  = arr_data[word_sel*WORD_W +: WORD_W];
    assign hit       = arr_valid && (arr_tag == tag);

    icache_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .clear_all (clear_all),
        .wr_en     (wr_en),
        .wr_idx    (idx),
        .wr_tag    (tag),
        .wr_data   (mem_data_in),
        .rd_idx    (idx),
        .rd_valid  (arr_valid),
        .rd_tag    (arr_tag),
        .rd_data   (arr_data)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        valid_d    = 1'b0;
        instr_d    = instr_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        req_seen_d = req_seen_q;
        refilled_d = refilled_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        clear_all  = 1'b0;
        wr_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    clear_all = 1'b1;
                end else if (cpu_req) begin
                    addr_d  = cpu_addr[CPU_ADDR_W-1:2];
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                refilled_d = 1'b0;
                if (hit) begin
                    instr_d = sel_word;
                    valid_d = 1'b1;
                    // The hit that completes a refill was already counted as a miss.
                    if (!refilled_q && hit_cnt_q != 16'hFFFF) begin
                        hit_cnt_d = hit_cnt_q + 16'd1;
                    end
                    state_d = IDLE;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = line_addr;
                    if (miss_cnt_q != 16'hFFFF) begin
                        miss_cnt_d = miss_cnt_q + 16'd1;
                    end
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (mem_req_q && !req_seen_q) begin
                    req_seen_d = 1'b1;
                end
                // A done level left over from an earlier refill is ignored until our request has been seen.
                if (req_seen_q && mem_done_in) begin
                    wr_en      = 1'b1;
                    mem_req_d  = 1'b0;
                    req_seen_d = 1'b0;
                    refilled_d = 1'b1;
                    state_d    = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            req_seen_q <= 1'b0;
            refilled_q <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            req_seen_q <= req_seen_d;
            refilled_q <= refilled_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign cpu_ready    = (state_q == IDLE);
    assign cpu_valid    = valid_q;
    assign cpu_instr    = instr_q;
    assign mem_req_out  = mem_req_q;
    assign mem_addr_out = mem_addr_q;
    assign hit_count    = hit_cnt_q;
    assign miss_count   = miss_cnt_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: directed fetches, 1-cycle memory model, decoupled monitor.
module tb_icache_ctrl;
    import icache_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  cpu_req;
    logic [CPU_ADDR_W-1:0] cpu_addr;
    logic                  cpu_ready;
    logic [WORD_W-1:0]     cpu_instr;
    logic                  cpu_valid;
    logic                  flush;
    logic                  mem_req_out;
    logic [MEM_ADDR_W-1:0] mem_addr_out;
    logic [LINE_W-1:0]     mem_data_in;
    logic                  mem_done_in;
    logic [15:0]           hit_count;
    logic [15:0]           miss_count;

    int checks = 0;
    int errors = 0;

    logic [WORD_W-1:0]     exp_instr_q [$];
    logic [MEM_ADDR_W-1:0] exp_mem_q   [$];

    bit hold_done = 0;
    int req_age   = 0;

    icache_ctrl #(.NUM_LINES(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_ready    (cpu_ready),
        .cpu_instr    (cpu_instr),
        .cpu_valid    (cpu_valid),
        .flush        (flush),
        .mem_req_out  (mem_req_out),
        .mem_addr_out (mem_addr_out),
        .mem_data_in  (mem_data_in),
        .mem_done_in  (mem_done_in),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [LINE_W-1:0] line_data(input logic [7:0] la);
        if (la == 8'h12) return {32'hD, 32'hC, 32'hB, 32'hA};
        return {16'hC0DE, la, 8'h03, 16'hC0DE, la, 8'h02,
                16'hC0DE, la, 8'h01, 16'hC0DE, la, 8'h00};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory: done + data one cycle after the request is first seen; done can be left held high.
    initial begin
        mem_done_in = 1'b0;
        mem_data_in = '0;
        forever begin
            @(negedge clk);
            if (mem_req_out === 1'b1) begin
                if (req_age >= 1) begin
                    mem_data_in = line_data(mem_addr_out);
                    mem_done_in = 1'b1;
                end
                req_age++;
            end else begin
                req_age = 0;
                if (!hold_done) mem_done_in = 1'b0;
            end
        end
    end

    // Monitor: pops expected refill addresses and instructions as the DUT presents them.
    initial begin
        logic mem_req_prev;
        logic [31:0] e;
        mem_req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req_out === 1'b1 && !mem_req_prev) begin
                if (exp_mem_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_addr: unexpected refill of %0h", mem_addr_out);
                end else begin
                    e = 32'(exp_mem_q.pop_front());
                    chk("mem_addr", 32'(mem_addr_out), e);
                end
            end
            if (cpu_valid === 1'b1) begin
                if (exp_instr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cpu_valid: unexpected pulse, instr %0h", cpu_instr);
                end else begin
                    e = exp_instr_q.pop_front();
                    chk("cpu_instr", cpu_instr, e);
                end
            end
            mem_req_prev = (mem_req_out === 1'b1);
        end
    end

    // Called and returning on a negedge.
    task automatic fetch(input logic [11:0] a, input logic [31:0] ei,
                         input bit miss, input logic [7:0] em);
        int lat;
        int w;
        exp_instr_q.push_back(ei);
        if (miss) exp_mem_q.push_back(em);
        w = 0;
        while (cpu_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) chk("ready_wait", 32'(cpu_ready), 32'd1);
        cpu_addr = a;
        cpu_req  = 1'b1;
        @(posedge clk);
        #1;
        cpu_req  = 1'b0;
        cpu_addr = 12'hFFF;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (cpu_valid !== 1'b1 && lat < 50);
        chk("latency", 32'(lat), miss ? 32'd4 : 32'd1);
    endtask

    task automatic chk_counts(input string name, input logic [15:0] eh, input logic [15:0] em);
        chk({name, "_hits"},   32'(hit_count),  32'(eh));
        chk({name, "_misses"}, 32'(miss_count), 32'(em));
    endtask

    initial begin
        reset    = 1'b1;
        cpu_req  = 1'b0;
        cpu_addr = '0;
        flush    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready",   32'(cpu_ready),    32'd1);
        chk("rst_valid",   32'(cpu_valid),    32'd0);
        chk("rst_instr",   cpu_instr,         32'd0);
        chk("rst_memreq",  32'(mem_req_out),  32'd0);
        chk("rst_memaddr", 32'(mem_addr_out), 32'd0);
        chk_counts("rst", 16'd0, 16'd0);
        reset = 1'b0;
        @(negedge clk);

        // Cold miss, then hit in the same line.
        fetch(12'h124, 32'hB, 1, 8'h12);
        chk_counts("cold", 16'd0, 16'd1);
        fetch(12'h12C, 32'hD, 0, 8'h00);
        chk_counts("hit", 16'd1, 16'd1);

        // Conflict on index 2 while done is held high from before.
        hold_done   = 1;
        mem_done_in = 1'b1;
        fetch(12'h224, 32'hC0DE2201, 1, 8'h22);
        chk_counts("conflict", 16'd1, 16'd2);
        fetch(12'h128, 32'hC, 1, 8'h12);
        chk_counts("back", 16'd1, 16'd3);
        hold_done = 0;
        @(negedge clk);

        // Flush wins over a same-cycle request.
        cpu_addr = 12'h124;
        cpu_req  = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        flush   = 1'b0;
        chk("flush_ready", 32'(cpu_ready), 32'd1);
        repeat (4) @(negedge clk);
        fetch(12'h124, 32'hB, 1, 8'h12);
        chk_counts("flush", 16'd1, 16'd4);

        // Reset while refilling.
        exp_mem_q.push_back(8'h30);
        cpu_addr = 12'h300;
        cpu_req  = 1'b1;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("refill_req", 32'(mem_req_out), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rstrefill_req",   32'(mem_req_out), 32'd0);
        chk("rstrefill_ready", 32'(cpu_ready),   32'd1);
        chk_counts("rstrefill", 16'd0, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        fetch(12'h300, 32'hC0DE3000, 1, 8'h30);
        chk_counts("after_rst", 16'd0, 16'd1);
        fetch(12'h124, 32'hB, 1, 8'h12);
        chk_counts("after_rst2", 16'd0, 16'd2);

        // Saturation: counter preloaded near the top, then hit past it.
        dut.hit_cnt_q <= 16'hFFF0;
        @(negedge clk);
        for (int i = 0; i < 15; i++) fetch(12'h124, 32'hB, 0, 8'h00);
        chk_counts("sat_top", 16'hFFFF, 16'd2);
        for (int i = 0; i < 5; i++) fetch(12'h124, 32'hB, 0, 8'h00);
        chk_counts("sat_hold", 16'hFFFF, 16'd2);

        repeat (3) @(negedge clk);
        chk("pending_instr", 32'(exp_instr_q.size()), 32'd0);
        chk("pending_mem",   32'(exp_mem_q.size()),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter: NUM_LINES, default 16, number of direct-mapped lines; power of 2, range 2..256.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_req  input  1  fetch request; sampled only while cpu_ready=1.
REQ-005 cpu_addr  input  12  byte address; [11:4] = line address, [3:2] = word select, [1:0] ignored.
REQ-006 cpu_ready  output  1  high only in IDLE; request accepted on an edge where cpu_req=1 and cpu_ready=1.
REQ-007 cpu_instr  output  32  fetched instruction; valid while cpu_valid=1.
REQ-008 cpu_valid  output  1  one-cycle pulse per accepted request.
REQ-009 flush  input  1  invalidate all lines; sampled only in IDLE.
REQ-010 mem_req_out  output  1  line refill request to instruction memory.
REQ-011 mem_addr_out  output  8  line address of refill; stable while mem_req_out=1.
REQ-012 mem_data_in  input  128  refill line; word k at bits [32k+31:32k].
REQ-013 mem_done_in  input  1  memory completion; may be held high indefinitely after any completion.
REQ-014 hit_count, miss_count  output  16 each  saturating performance counters.

Function
REQ-015 Index = cpu_addr[4+log2(NUM_LINES)-1:4]; tag = cpu_addr[11:4+log2(NUM_LINES)]; per line: valid bit, tag, 128-bit data.
REQ-016 FSM states IDLE, COMPARE, REFILL; reset state IDLE.
REQ-017 IDLE: flush=1 -> clear all valid bits, stay IDLE, drop any cpu_req that cycle (flush wins); else cpu_req=1 -> register cpu_addr, go COMPARE.
REQ-018 COMPARE: hit (valid and tag match) -> cpu_instr <= selected word, cpu_valid <= 1, hit_count++, go IDLE.
REQ-019 COMPARE: miss -> mem_req_out <= 1, mem_addr_out <= registered cpu_addr[11:4], miss_count++, go REFILL.
REQ-020 REFILL: internal flag req_seen set on first edge with mem_req_out=1; mem_done_in ignored until req_seen=1 (tolerates level-held done from a prior refill).
REQ-021 REFILL: mem_done_in=1 and req_seen=1 -> write mem_data_in, tag, valid=1 into indexed line; mem_req_out <= 0; clear req_seen; go COMPARE (guaranteed hit).
REQ-022 Latency with 1-cycle memory: request accepted at edge 0 -> hit: cpu_valid high in cycle after edge 1; miss: mem_req_out high cycles 1-2, line written edge 3, cpu_valid after edge 4.
REQ-023 cpu_valid and cpu_instr register; cpu_valid is 0 in every cycle not following a hit in COMPARE; cpu_instr holds last value otherwise.
REQ-024 Counters saturate at 16'hFFFF; no wrap; each miss counted once (not again on the post-refill hit).
REQ-025 cpu_addr, cpu_req, flush changes outside IDLE have no effect.
REQ-026 Refill of a line overwrites any previous tag in that index (no victim write-back; read-only cache).

Reset
REQ-027 reset=1 at an edge: state IDLE, all valid bits 0, cpu_valid=0, cpu_instr=0, mem_req_out=0, mem_addr_out=0, req_seen=0, both counters 0.
REQ-028 Reset during REFILL: request dropped, line not written, mem_req_out low after that edge.
REQ-029 Data and tag arrays need no reset; only valid bits.

Structure
REQ-030 Package icache_pkg: state enum, CPU_ADDR_W=12, MEM_ADDR_W=8, LINE_W=128, WORD_W=32.
REQ-031 One sub-module icache_array: valid/tag/data storage, one write port, one combinational read port; FSM and counters in icache_ctrl.

Verification
REQ-032 Cold miss: reset, cpu_addr=12'h124 with memory line 8'h12 = {32'hD,32'hC,32'hB,32'hA} -> mem_addr_out=8'h12, cpu_valid after edge 4, cpu_instr=32'hB, miss_count=1.
REQ-033 Hit: then cpu_addr=12'h12C -> cpu_valid after edge 1, cpu_instr=32'hD, no mem_req_out, hit_count=1.
REQ-034 Conflict: cpu_addr=12'h224 (same index, new tag), mem_done_in held high from prior refill -> done ignored until req_seen, line replaced, cpu_instr = new line word 1.
REQ-035 Flush and cpu_req same cycle in IDLE -> request dropped, no cpu_valid; next fetch of 12'h124 misses (miss_count increments).
REQ-036 Reset asserted during REFILL -> mem_req_out 0 after edge, fetch of same address afterwards misses.
REQ-037 Counter saturation: preload via 65536+ hits -> hit_count stays 16'hFFFF.
